// File: rtl/intr_ctrl_pkg.sv
// Shared constants for the interrupt controller: IO port offsets and CAUSE encoding.
package intr_ctrl_pkg;

  localparam int MASK_OFS      = 0;
  localparam int PEND_OFS      = 1;
  localparam int CAUSE_OFS     = 2;
  localparam int CAUSE_VLD_BIT = 7;

  function automatic logic [7:0] cause_code(input logic [2:0] idx);
    logic [7:0] c;
    c = 8'h00;
    c[CAUSE_VLD_BIT] = 1'b1;
    c[2:0] = idx;
    return c;
  endfunction

endpackage

// File: rtl/intr_ctrl_sync.sv
// Single-source synchroniser and rising-edge detector with a settle-inhibit gate.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic irq,
  input  logic inhibit,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // last_q keeps tracking during inhibit, so a level held through reset is never seen as an edge
  assign edge_det = sync_q[SYNC_STAGES-1] & ~last_q & ~inhibit;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask, global I flag,
// lowest-index priority, CAUSE capture on acknowledge and an IO register window.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int         NUM_SRC     = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BASE_ID     = 8'hF0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ,
  input  logic               I_SET,
  input  logic               I_CLR,
  input  logic               INT_ACK,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               IO_STRB,
  output logic               INT,
  output logic [7:0]         IN_DATA,
  output logic               I_FLAG
);

  localparam int         SETTLE   = SYNC_STAGES + 1;
  localparam int         CW       = $clog2(SETTLE + 1);
  localparam logic [7:0] ID_MASK  = BASE_ID + 8'(MASK_OFS);
  localparam logic [7:0] ID_PEND  = BASE_ID + 8'(PEND_OFS);
  localparam logic [7:0] ID_CAUSE = BASE_ID + 8'(CAUSE_OFS);

  logic [CW-1:0]      settle_cnt;
  logic               inhibit;
  logic [NUM_SRC-1:0] edge_vec;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [7:0]         cause_q;
  logic               i_flag_q;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] win_oh;
  logic [2:0]         win_idx;
  logic               have_win;
  logic               wr_mask;
  logic               wr_pend;
  logic [NUM_SRC-1:0] pend_clr;
  logic               unused_out_port;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) settle_cnt <= CW'(SETTLE);
    else if (settle_cnt != '0) settle_cnt <= settle_cnt - CW'(1);
  end

  assign inhibit = (settle_cnt != '0);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLK      (CLK),
      .RESET    (RESET),
      .irq      (IRQ[g]),
      .inhibit  (inhibit),
      .edge_det (edge_vec[g])
    );
  end

  assign req = pend_q & mask_q;

  // descending scan so the lowest set index is the last to assign
  always_comb begin
    win_idx  = 3'd0;
    win_oh   = '0;
    have_win = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx   = 3'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
        have_win  = 1'b1;
      end
    end
  end

  assign wr_mask  = IO_STRB && (PORT_ID == ID_MASK);
  assign wr_pend  = IO_STRB && (PORT_ID == ID_PEND);
  assign pend_clr = ((INT_ACK && have_win) ? win_oh : '0)
                  | (wr_pend ? OUT_PORT[NUM_SRC-1:0] : '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      i_flag_q <= 1'b0;
      mask_q   <= '0;
      pend_q   <= '0;
      cause_q  <= 8'h00;
    end else begin
      if (I_CLR)      i_flag_q <= 1'b0;
      else if (I_SET) i_flag_q <= 1'b1;
      if (wr_mask) mask_q <= OUT_PORT[NUM_SRC-1:0];
      // new edges override any clear landing on the same cycle
      pend_q <= (pend_q & ~pend_clr) | edge_vec;
      if (INT_ACK) cause_q <= have_win ? cause_code(win_idx) : 8'h00;
    end
  end

  always_comb begin
    IN_DATA = 8'h00;
    if (PORT_ID == ID_MASK)       IN_DATA = 8'(mask_q);
    else if (PORT_ID == ID_PEND)  IN_DATA = 8'(pend_q);
    else if (PORT_ID == ID_CAUSE) IN_DATA = cause_q;
  end

  assign INT    = i_flag_q & (|req);
  assign I_FLAG = i_flag_q;

  assign unused_out_port = ^(OUT_PORT >> NUM_SRC);

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: reset gating, priority, mask/W1C, collisions, async reset.
module tb_intr_ctrl;

  localparam logic [7:0] ID_MASK  = 8'hF0;
  localparam logic [7:0] ID_PEND  = 8'hF1;
  localparam logic [7:0] ID_CAUSE = 8'hF2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] IRQ;
  logic       I_SET, I_CLR, INT_ACK, IO_STRB;
  logic [7:0] PORT_ID, OUT_PORT;
  logic       INT, I_FLAG;
  logic [7:0] IN_DATA;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rd_val;

  intr_ctrl #(.NUM_SRC(4), .SYNC_STAGES(2), .BASE_ID(8'hF0)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IRQ      (IRQ),
    .I_SET    (I_SET),
    .I_CLR    (I_CLR),
    .INT_ACK  (INT_ACK),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .INT      (INT),
    .IN_DATA  (IN_DATA),
    .I_FLAG   (I_FLAG)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] d);
    PORT_ID = id;
    #1;
    d = IN_DATA;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    step();
    IO_STRB  = 1'b0;
  endtask

  task automatic pulse_iset();
    I_SET = 1'b1;
    step();
    I_SET = 1'b0;
  endtask

  task automatic ack(input logic with_clr);
    INT_ACK = 1'b1;
    I_CLR   = with_clr;
    step();
    INT_ACK = 1'b0;
    I_CLR   = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; IRQ = 4'b0001; I_SET = 0; I_CLR = 0; INT_ACK = 0;
    IO_STRB = 0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    step(3);
    check("rst_int", INT, 8'h0);
    check("rst_iflag", I_FLAG, 8'h0);
    rd(ID_MASK, rd_val);  check("rst_mask", rd_val, 8'h00);
    rd(ID_PEND, rd_val);  check("rst_pend", rd_val, 8'h00);
    rd(ID_CAUSE, rd_val); check("rst_cause", rd_val, 8'h00);

    // 1. IRQ[0] held high through reset must never pend
    RESET = 1'b0;
    step(10);
    rd(ID_PEND, rd_val); check("gate_pend", rd_val, 8'h00);
    check("gate_int", INT, 8'h0);
    IRQ = 4'b0000; step(4);
    IRQ = 4'b0001; step(4);
    rd(ID_PEND, rd_val); check("gate_edge_pend", rd_val, 8'h01);
    wr(ID_PEND, 8'h01);
    rd(ID_PEND, rd_val); check("gate_w1c", rd_val, 8'h00);
    IRQ = 4'b0000; step(4);

    // 2. basic path and latency
    wr(ID_MASK, 8'h01);
    pulse_iset();
    check("basic_iflag", I_FLAG, 8'h1);
    IRQ = 4'b0001;
    step(); check("basic_lat1", INT, 8'h0);
    step(); check("basic_lat2", INT, 8'h0);
    step(); check("basic_lat3", INT, 8'h1);
    ack(1'b1);
    check("basic_ack_int", INT, 8'h0);
    check("basic_ack_iflag", I_FLAG, 8'h0);
    rd(ID_CAUSE, rd_val); check("basic_cause", rd_val, 8'h80);
    rd(ID_PEND, rd_val);  check("basic_pend", rd_val, 8'h00);
    IRQ = 4'b0000;

    // 3. priority
    wr(ID_MASK, 8'h0F);
    IRQ = 4'b1010; step(4);
    pulse_iset();
    check("prio_int", INT, 8'h1);
    rd(ID_PEND, rd_val); check("prio_pend0", rd_val, 8'h0A);
    ack(1'b1);
    rd(ID_CAUSE, rd_val); check("prio_cause1", rd_val, 8'h81);
    rd(ID_PEND, rd_val);  check("prio_pend1", rd_val, 8'h08);
    check("prio_int1", INT, 8'h0);
    pulse_iset();
    check("prio_int2", INT, 8'h1);
    ack(1'b1);
    rd(ID_CAUSE, rd_val); check("prio_cause2", rd_val, 8'h83);
    rd(ID_PEND, rd_val);  check("prio_pend2", rd_val, 8'h00);
    IRQ = 4'b0000; step(4);

    // 4. mask and write-1-to-clear
    wr(ID_MASK, 8'h00);
    pulse_iset();
    IRQ = 4'b0100; step(4);
    rd(ID_PEND, rd_val); check("mask_pend", rd_val, 8'h04);
    check("mask_int_off", INT, 8'h0);
    wr(ID_MASK, 8'h04);
    check("mask_int_on", INT, 8'h1);
    wr(ID_PEND, 8'h04);
    check("w1c_int", INT, 8'h0);
    rd(ID_PEND, rd_val); check("w1c_pend", rd_val, 8'h00);
    IRQ = 4'b0000; step(4);

    // 5. collisions
    I_SET = 1'b1; I_CLR = 1'b1; step();
    I_SET = 1'b0; I_CLR = 1'b0;
    check("coll_iflag", I_FLAG, 8'h0);
    IRQ = 4'b0001; step(2);
    wr(ID_PEND, 8'h01);
    rd(ID_PEND, rd_val); check("coll_set_wins", rd_val, 8'h01);
    wr(ID_PEND, 8'h01);
    rd(ID_PEND, rd_val); check("coll_w1c_after", rd_val, 8'h00);
    ack(1'b0);
    rd(ID_CAUSE, rd_val); check("spurious_cause", rd_val, 8'h00);

    // 6. async reset while INT is high
    wr(ID_MASK, 8'h01);
    pulse_iset();
    IRQ = 4'b0000; step(4);
    IRQ = 4'b0001; step(4);
    check("pre_rst_int", INT, 8'h1);
    ack(1'b0);
    rd(ID_CAUSE, rd_val); check("pre_rst_cause", rd_val, 8'h80);
    IRQ = 4'b0000; step(4);
    IRQ = 4'b0001; step(4);
    check("pre_rst_int2", INT, 8'h1);
    rd(8'h10, rd_val); check("unmapped_rd", rd_val, 8'h00);
    #1;
    RESET = 1'b1;
    #1;
    check("arst_int", INT, 8'h0);
    check("arst_iflag", I_FLAG, 8'h0);
    rd(ID_MASK, rd_val);  check("arst_mask", rd_val, 8'h00);
    rd(ID_CAUSE, rd_val); check("arst_cause", rd_val, 8'h00);
    rd(ID_PEND, rd_val);  check("arst_pend", rd_val, 8'h00);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
